// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: WB-stage exception/ERTN commit sequencer with flush and fetch redirect
module exc_commit_ctrl #(
  parameter int ECNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [31:0]       wb_pc,
  input  logic [31:0]       wb_vaddr,
  input  logic [5:0]        wb_exc,
  input  logic              wb_is_ertn,
  input  logic              csr_has_int,
  input  logic [31:0]       csr_ex_entry,
  input  logic [31:0]       csr_era,
  output logic              csr_wb_ex,
  output logic              csr_ertn_flush,
  output logic [31:0]       csr_wb_pc,
  output logic [31:0]       csr_wb_vaddr,
  output logic [5:0]        csr_wb_ecode,
  output logic [8:0]        csr_wb_esubcode,
  output logic              wb_commit,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  input  logic              redirect_ready,
  output logic [ECNT_W-1:0] exc_cnt
);
  typedef enum logic {IDLE, REDIR} state_t;
  state_t state, state_nx;
  logic idle, v, ex_take, ertn_take, adem_only;
  logic [5:0] ecode;
  // Event decode, fixed-priority ecode selection, strobes and next state
  always_comb begin
    idle = state == IDLE;
    v = idle & wb_valid & resetn;
    ex_take = v & (csr_has_int | (|wb_exc));
    ertn_take = v & wb_is_ertn & ~ex_take;
    ecode = csr_has_int ? 6'h00 :
            wb_exc[0]   ? 6'h08 :
            wb_exc[1]   ? 6'h0D :
            wb_exc[2]   ? 6'h0B :
            wb_exc[3]   ? 6'h0C :
            wb_exc[4]   ? 6'h09 : 6'h08;
    adem_only = ~csr_has_int & ~(|wb_exc[4:0]) & wb_exc[5];
    wb_ready = idle;
    csr_wb_ex = ex_take;
    csr_ertn_flush = ertn_take;
    csr_wb_pc = ex_take ? wb_pc : 32'h0;
    csr_wb_vaddr = ex_take ? wb_vaddr : 32'h0;
    csr_wb_ecode = ex_take ? ecode : 6'h0;
    csr_wb_esubcode = {8'h0, ex_take & adem_only};
    wb_commit = v & ~ex_take & ~ertn_take;
    redirect_valid = resetn & ~idle;
    flush = ex_take | ertn_take | redirect_valid;
    state_nx = idle ? ((ex_take | ertn_take) ? REDIR : IDLE) : (redirect_ready ? IDLE : REDIR);
  end
  // State, latched redirect target and saturating exception counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      redirect_pc <= 32'h0;
      exc_cnt <= '0;
    end else begin
      state <= state_nx;
      if (ex_take) begin
        redirect_pc <= csr_ex_entry;
        if (~&exc_cnt) exc_cnt <= exc_cnt + ECNT_W'(1);
      end else if (ertn_take) redirect_pc <= csr_era;
    end
  end
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed self-checking bench for exc_commit_ctrl
module tb_exc_commit_ctrl;
  logic clk = 0, resetn = 0;
  logic wb_valid = 0, wb_is_ertn = 0, csr_has_int = 0, redirect_ready = 1;
  logic [31:0] wb_pc = 0, wb_vaddr = 0, csr_ex_entry = 0, csr_era = 0;
  logic [5:0] wb_exc = 0;
  logic wb_ready, csr_wb_ex, csr_ertn_flush, wb_commit, flush, redirect_valid;
  logic [31:0] csr_wb_pc, csr_wb_vaddr, redirect_pc;
  logic [5:0] csr_wb_ecode;
  logic [8:0] csr_wb_esubcode;
  logic [1:0] exc_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.ECNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_exc(wb_exc), .wb_is_ertn(wb_is_ertn),
    .csr_has_int(csr_has_int), .csr_ex_entry(csr_ex_entry), .csr_era(csr_era),
    .csr_wb_ex(csr_wb_ex), .csr_ertn_flush(csr_ertn_flush), .csr_wb_pc(csr_wb_pc),
    .csr_wb_vaddr(csr_wb_vaddr), .csr_wb_ecode(csr_wb_ecode),
    .csr_wb_esubcode(csr_wb_esubcode), .wb_commit(wb_commit), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_cnt(exc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] e, input logic er, input logic it);
    wb_valid = v; wb_exc = e; wb_is_ertn = er; csr_has_int = it;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1;
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_exc_cnt", exc_cnt, 0);
    chk("rst_commit", wb_commit, 0);
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    drive(1, 6'b0, 0, 0);
    chk("retire_commit", wb_commit, 1);
    chk("retire_ex", csr_wb_ex, 0);
    chk("retire_flush", flush, 0);
    chk("retire_ready", wb_ready, 1);
    tick();
    wb_pc = 32'h1c000100; wb_vaddr = 32'h0000abcd; csr_ex_entry = 32'h1c008000;
    drive(1, 6'b010010, 0, 0);
    chk("multi_ex", csr_wb_ex, 1);
    chk("multi_ecode", csr_wb_ecode, 6'h0D);
    chk("multi_esub", csr_wb_esubcode, 0);
    chk("multi_pc", csr_wb_pc, 32'h1c000100);
    chk("multi_vaddr", csr_wb_vaddr, 32'h0000abcd);
    chk("multi_flush", flush, 1);
    chk("multi_commit", wb_commit, 0);
    tick();
    chk("redir_valid", redirect_valid, 1);
    chk("redir_pc", redirect_pc, 32'h1c008000);
    chk("redir_cnt", exc_cnt, 1);
    chk("redir_no_ex", csr_wb_ex, 0);
    chk("redir_ready", wb_ready, 0);
    chk("redir_flush", flush, 1);
    tick();
    drive(0, 6'b0, 0, 1);
    chk("idle_back", redirect_valid, 0);
    chk("novalid_int_ignored", csr_wb_ex, 0);
    chk("novalid_commit", wb_commit, 0);
    drive(1, 6'b0, 1, 1);
    chk("int_ertn_ex", csr_wb_ex, 1);
    chk("int_ertn_ecode", csr_wb_ecode, 6'h00);
    chk("int_ertn_noertn", csr_ertn_flush, 0);
    tick();
    tick();
    csr_era = 32'h1c000444;
    drive(1, 6'b0, 1, 0);
    chk("ertn_flush", csr_ertn_flush, 1);
    chk("ertn_no_ex", csr_wb_ex, 0);
    chk("ertn_ecode_zero", csr_wb_ecode, 0);
    chk("ertn_commit", wb_commit, 0);
    tick();
    chk("ertn_pulse", csr_ertn_flush, 0);
    chk("ertn_redir_pc", redirect_pc, 32'h1c000444);
    chk("ertn_cnt", exc_cnt, 2);
    tick();
    redirect_ready = 0;
    drive(1, 6'b000001, 0, 0);
    chk("adef_ecode", csr_wb_ecode, 6'h08);
    chk("adef_esub", csr_wb_esubcode, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", redirect_valid, 1);
      chk("bp_no_ex", csr_wb_ex, 0);
      chk("bp_ready", wb_ready, 0);
      tick();
    end
    chk("bp_cnt", exc_cnt, 3);
    redirect_ready = 1;
    #1;
    chk("bp_accept_valid", redirect_valid, 1);
    tick();
    chk("bp_idle_ready", wb_ready, 1);
    chk("bp_next_eval", csr_wb_ex, 1);
    tick();
    chk("sat_cnt", exc_cnt, 3);
    tick();
    drive(1, 6'b100000, 0, 0);
    chk("adem_ecode", csr_wb_ecode, 6'h08);
    chk("adem_esub", csr_wb_esubcode, 1);
    drive(1, 6'b110000, 0, 0);
    chk("ale_ecode", csr_wb_ecode, 6'h09);
    chk("ale_esub", csr_wb_esubcode, 0);
    drive(1, 6'b001100, 0, 0);
    chk("sys_ecode", csr_wb_ecode, 6'h0B);
    drive(1, 6'b001000, 0, 0);
    chk("brk_ecode", csr_wb_ecode, 6'h0C);
    tick();
    redirect_ready = 0;
    #1;
    chk("mid_redir_valid", redirect_valid, 1);
    resetn = 0;
    #1;
    chk("mid_rst_valid", redirect_valid, 0);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_cnt", exc_cnt, 0);
    tick();
    resetn = 1;
    redirect_ready = 1;
    drive(1, 6'b0, 0, 0);
    chk("post_rst_commit", wb_commit, 1);
    chk("post_rst_flush", flush, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 6'b000010, 0, 0);
      chk("sat_ex", csr_wb_ex, 1);
      tick();
      chk("sat_seq", exc_cnt, (i < 3) ? i + 1 : 3);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
